// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, reset vector and state encoding for the PC sequencer
package pc_sequencer_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_VEC_DEFAULT = 16'h0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_FETCH  = 3'd2;
  localparam state_t ST_ISSUE  = 3'd3;
  localparam state_t ST_UPDATE = 3'd4;
  localparam state_t ST_HALTED = 3'd5;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue/update sequencer steering an external program counter
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [WORD_W-1:0] pc_q,
  output logic              pc_load,
  output logic              pc_inc,
  output logic [WORD_W-1:0] pc_d,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  input  logic              instr_ready,
  input  logic              jump_req,
  input  logic [WORD_W-1:0] jump_addr,
  output logic              jump_ack,
  output logic              busy
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= '0;
    end else if (state == ST_FETCH && mem_ack) begin
      instr <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (instr_ready) state_nxt = ST_UPDATE;
      // The PC update always happens in UPDATE; halt only chooses where we go afterwards.
      ST_UPDATE: state_nxt = halt ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (start) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are pure decode of state so reset (which forces IDLE) zeroes them at once.
  always_comb begin
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_d        = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    jump_ack    = 1'b0;
    case (state)
      ST_LOAD: begin
        pc_load = 1'b1;
        pc_d    = RESET_VEC;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
      end
      ST_UPDATE: begin
        if (jump_req) begin
          pc_load  = 1'b1;
          pc_d     = jump_addr;
          jump_ack = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0100;

  logic        clk = 1'b0;
  logic        reset, start, halt, mem_ack, instr_ready, jump_req;
  logic [15:0] mem_rdata, jump_addr;
  logic        pc_load, pc_inc, mem_req, instr_valid, jump_ack, busy;
  logic [15:0] pc_d, mem_addr, instr;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_LOAD, M_FETCH, M_ISSUE, M_UPDATE, M_HALT} mph_t;
  mph_t        ph = M_IDLE;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [53:0] obs;

  typedef struct {
    logic        s;
    logic        a;
    logic        rdy;
    logic [15:0] rd;
    logic [53:0] exp;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VEC(RV)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc_q(m_pc),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .jump_req(jump_req), .jump_addr(jump_addr), .jump_ack(jump_ack), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic a, input logic rdy, input logic [15:0] rd,
                              input logic [5:0] f, input logic [15:0] ad, input logic [15:0] pd,
                              input logic [15:0] ins);
    vec_t v;
    v.s = s; v.a = a; v.rdy = rdy; v.rd = rd;
    v.exp = {f, ad, pd, ins};
    return v;
  endfunction

  // Layout: {busy, mem_req, pc_load, pc_inc, instr_valid, jump_ack, mem_addr, pc_d, instr}
  function automatic logic [53:0] model_out();
    logic jmp, stp;
    logic [15:0] a, d;
    if (!reset) return '0;
    jmp = (ph == M_UPDATE) && jump_req;
    stp = (ph == M_UPDATE) && !jump_req;
    a = (ph == M_FETCH) ? m_pc : 16'h0000;
    d = (ph == M_LOAD) ? RV : (jmp ? jump_addr : 16'h0000);
    return {(ph != M_IDLE) && (ph != M_HALT), ph == M_FETCH, (ph == M_LOAD) || jmp, stp,
            ph == M_ISSUE, jmp, a, d, m_instr};
  endfunction

  task automatic model_advance();
    if (!reset) begin
      ph = M_IDLE;
      m_instr = 16'h0000;
    end else begin
      case (ph)
        M_IDLE:   if (start) ph = M_LOAD;
        M_LOAD:   begin m_pc = RV; ph = M_FETCH; end
        M_FETCH:  if (mem_ack) begin m_instr = mem_rdata; ph = M_ISSUE; end
        M_ISSUE:  if (instr_ready) ph = M_UPDATE;
        M_UPDATE: begin
          m_pc = jump_req ? jump_addr : m_pc + 16'h0001;
          ph = halt ? M_HALT : M_FETCH;
        end
        default:  if (start) ph = M_FETCH;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic h, input logic a,
                       input logic [15:0] rd, input logic rdy, input logic j,
                       input logic [15:0] ja);
    reset = r; start = s; halt = h; mem_ack = a; mem_rdata = rd;
    instr_ready = rdy; jump_req = j; jump_addr = ja;
    if (!r) begin
      ph = M_IDLE;
      m_instr = 16'h0000;
    end
    #1;
    obs = {busy, mem_req, pc_load, pc_inc, instr_valid, jump_ack, mem_addr, pc_d, instr};
    chk("model", obs, model_out());
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    logic        rj;
    logic [15:0] rja;
    logic        r;

    tbl[0]  = mk(1, 0, 0, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 6'b101000, 16'h0000, 16'h0100, 16'h0000);
    tbl[2]  = mk(0, 1, 0, 16'hA001, 6'b110000, 16'h0100, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 1, 16'h0000, 6'b100010, 16'h0000, 16'h0000, 16'hA001);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 6'b100100, 16'h0000, 16'h0000, 16'hA001);
    tbl[5]  = mk(0, 1, 0, 16'hA002, 6'b110000, 16'h0101, 16'h0000, 16'hA001);
    tbl[6]  = mk(0, 0, 1, 16'h0000, 6'b100010, 16'h0000, 16'h0000, 16'hA002);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 6'b100100, 16'h0000, 16'h0000, 16'hA002);
    tbl[8]  = mk(0, 1, 0, 16'hA003, 6'b110000, 16'h0102, 16'h0000, 16'hA002);
    tbl[9]  = mk(0, 0, 1, 16'h0000, 6'b100010, 16'h0000, 16'h0000, 16'hA003);
    tbl[10] = mk(0, 0, 0, 16'h0000, 6'b100100, 16'h0000, 16'h0000, 16'hA003);
    tbl[11] = mk(0, 0, 0, 16'h0000, 6'b110000, 16'h0103, 16'h0000, 16'hA003);

    reset = 1'b0; start = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    instr_ready = 1'b0; jump_req = 1'b0; jump_addr = 16'h0000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, 16'hFFFF, 1, 1, 16'h5555);
      chk("reset_outputs", obs, 54'h0);
    end
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);

    // Start latency and zero-wait sequential fetch
    for (int i = 0; i < 12; i++) begin
      cycle(1, tbl[i].s, 0, tbl[i].a, tbl[i].rd, tbl[i].rdy, 0, 16'h0000);
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Wait states: memory ack late by 4, ready late by 2
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 16'hDEAD, 0, 0, 16'h0000);
      chk("wait_mem_req", {obs[52], obs[51:50], obs[47:32]}, {1'b1, 2'b00, 16'h0103});
    end
    cycle(1, 0, 0, 1, 16'hB0B0, 0, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 1, 16'h1111, 0, 0, 16'h0000);
      chk("wait_issue", {obs[49], obs[51:50], obs[15:0]}, {1'b1, 2'b00, 16'hB0B0});
    end
    cycle(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cycle(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    chk("wait_update_inc", obs[51:50], 2'b01);

    // Jump raised during FETCH, taken only in UPDATE
    cycle(1, 0, 0, 0, 16'h0000, 0, 1, 16'h1234);
    chk("jump_fetch_noack", {obs[48], obs[51], obs[47:32]}, {1'b0, 1'b0, 16'h0104});
    cycle(1, 0, 0, 1, 16'hC0DE, 0, 1, 16'h1234);
    cycle(1, 0, 0, 0, 16'h0000, 1, 1, 16'h1234);
    chk("jump_issue_noack", {obs[48], obs[51]}, 2'b00);
    cycle(1, 0, 0, 0, 16'h0000, 0, 1, 16'h1234);
    chk("jump_update", {obs[51], obs[50], obs[48], obs[31:16]}, {3'b101, 16'h1234});
    cycle(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    chk("jump_next_addr", {obs[52], obs[47:32]}, {1'b1, 16'h1234});

    // Halt at the top of the address space, then resume from the wrapped PC
    m_pc = 16'hFFFF;
    cycle(1, 0, 0, 1, 16'h7777, 0, 0, 16'h0000);
    chk("wrap_fetch_addr", obs[47:32], 16'hFFFF);
    cycle(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000);
    cycle(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000);
    chk("halt_update_inc", obs[51:50], 2'b01);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 1, 16'h0000, 1, 1, 16'h4321);
      chk("halted_idle", obs[53:48], 6'b000000);
    end
    cycle(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000);
    chk("halted_start_noload", obs[53:50], 4'b0000);
    cycle(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    chk("resume_addr", {obs[52], obs[51], obs[47:32]}, {2'b10, 16'h0000});

    // Reset while fetching with a jump pending
    cycle(0, 0, 0, 0, 16'h0000, 0, 1, 16'h2222);
    chk("reset_mid_fetch", obs, 54'h0);
    cycle(0, 0, 0, 1, 16'h0000, 1, 1, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 16'h0000, 1, 1, 16'h2222);
      chk("post_reset_idle", obs[53:48], 6'b000000);
    end

    // Randomised traffic against the reference model
    rj = 1'b0;
    rja = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 149) != 0);
      if (!rj && $urandom_range(0, 5) == 0) begin
        rj = 1'b1;
        rja = 16'($urandom);
      end
      cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 1)), rj, rja);
      if (obs[48]) rj = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
